// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: one-hot state encoding,
// error codes and a small popcount helper.
package cmd_pkg;

    localparam int S_IDLE         = 0;
    localparam int S_GET_CC       = 1;
    localparam int S_GET_CDC      = 2;
    localparam int S_START        = 3;
    localparam int S_PAUSE        = 4;
    localparam int S_TEST_RUNNING = 5;
    localparam int S_ILLEGAL      = 6;
    localparam int S_ERROR        = 7;
    localparam int S_WAIT_DONE    = 8;
    localparam int S_DRAIN        = 9;
    localparam int S_DONE         = 10;
    localparam int N_STATES       = 11;

    typedef enum logic [N_STATES-1:0] {
        ST_IDLE         = 11'h001,
        ST_GET_CC       = 11'h002,
        ST_GET_CDC      = 11'h004,
        ST_START        = 11'h008,
        ST_PAUSE        = 11'h010,
        ST_TEST_RUNNING = 11'h020,
        ST_ILLEGAL      = 11'h040,
        ST_ERROR        = 11'h080,
        ST_WAIT_DONE    = 11'h100,
        ST_DRAIN        = 11'h200,
        ST_DONE         = 11'h400
    } state_e;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL_CC = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd2;
    localparam logic [2:0] ERR_SHORT      = 3'd3;
    localparam logic [2:0] ERR_MULTI      = 3'd4;
    localparam logic [2:0] ERR_COUNT      = 3'd5;

    // Callers zero-extend; supports up to 64 handlers.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// WAIT_DONE watchdog: counts enabled cycles since the last clear and flags
// the final permitted cycle. TIMEOUT_CYC of 0 disables it.
module cmd_timeout_timer #(
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    // Asserted in the TIMEOUT_CYC-th enabled cycle, so the owner spends exactly
    // TIMEOUT_CYC cycles waiting before it acts on the timeout.
    assign expired = (TIMEOUT_CYC != 0) && enable && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear)                 cnt_d = '0;
        else if (enable && !expired && (TIMEOUT_CYC != 0)) cnt_d = cnt_q + TO_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cmd_dispatch_sm.sv
// Command-packet front end: parses CSN/CC/CDC from the rx stream, hands the
// command to exactly one claiming handler, forwards payload and reports errors.
module cmd_dispatch_sm
    import cmd_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int N_HANDLERS  = 8,
    parameter int TIMEOUT_CYC = 65535,
    parameter int TO_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_tvalid,
    input  logic [DATA_W-1:0]     rx_tdata,
    input  logic                  rx_tlast,
    output logic                  rx_tready,
    input  logic                  hdl_rx_tready,
    output logic [DATA_W-1:0]     csn,
    output logic [DATA_W-1:0]     cmd_code,
    output logic [DATA_W-1:0]     cmd_count,
    output logic                  run_cmd_sm,
    input  logic [N_HANDLERS-1:0] cmd_sm_running,
    input  logic [N_HANDLERS-1:0] cmd_sm_done,
    output logic                  cmd_done,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic                  busy
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] csn_q, csn_d, cmd_code_q, cmd_code_d;
    logic [DATA_W-1:0] cmd_count_q, cmd_count_d, pl_cnt_q, pl_cnt_d;
    logic              frame_end_q, frame_end_d;
    logic              err_valid_q, err_valid_d;
    logic [2:0]        err_code_q, err_code_d;
    logic              xfer, to_expired, any_done;
    logic [6:0]        n_claim;

    cmd_timeout_timer #(.TO_W(TO_W), .TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q[S_TEST_RUNNING]),
        .enable  (state_q[S_WAIT_DONE]),
        .expired (to_expired)
    );

    assign n_claim  = popcount(64'(cmd_sm_running));
    assign any_done = |cmd_sm_done;
    assign xfer     = rx_tvalid & rx_tready;

    always_comb begin
        rx_tready = state_q[S_IDLE] | state_q[S_GET_CC] | state_q[S_GET_CDC] | state_q[S_DRAIN]
                  | (state_q[S_WAIT_DONE] & hdl_rx_tready & ~frame_end_q);
    end

    always_comb begin
        state_d     = state_q;
        csn_d       = csn_q;
        cmd_code_d  = cmd_code_q;
        cmd_count_d = cmd_count_q;
        pl_cnt_d    = pl_cnt_q;
        frame_end_d = frame_end_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        unique case (1'b1)
            state_q[S_IDLE]: if (xfer) begin
                if (rx_tlast) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                end else begin
                    csn_d   = rx_tdata;
                    state_d = ST_GET_CC;
                end
            end
            state_q[S_GET_CC]: if (xfer) begin
                if (rx_tlast) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                    state_d     = ST_DONE;
                end else begin
                    cmd_code_d = rx_tdata;
                    state_d    = ST_GET_CDC;
                end
            end
            state_q[S_GET_CDC]: if (xfer) begin
                cmd_count_d = rx_tdata;
                frame_end_d = rx_tlast;
                if (rx_tlast && rx_tdata != '0) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_START;
                end
            end
            state_q[S_START]: state_d = ST_PAUSE;
            state_q[S_PAUSE]: state_d = ST_TEST_RUNNING;
            state_q[S_TEST_RUNNING]: begin
                pl_cnt_d = '0;
                if (n_claim == 7'd0)      state_d = ST_ILLEGAL;
                else if (n_claim == 7'd1) state_d = ST_WAIT_DONE;
                else begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_MULTI;
                    state_d     = ST_ERROR;
                end
            end
            state_q[S_ILLEGAL]: begin
                err_valid_d = 1'b1;
                err_code_d  = ERR_ILLEGAL_CC;
                state_d     = frame_end_q ? ST_DONE : ST_DRAIN;
            end
            state_q[S_ERROR]: state_d = frame_end_q ? ST_DONE : ST_DRAIN;
            state_q[S_WAIT_DONE]: begin
                if (xfer) begin
                    if (pl_cnt_q != '1) pl_cnt_d = pl_cnt_q + DATA_W'(1);
                    if (rx_tlast)       frame_end_d = 1'b1;
                end
                // A word accepted alongside done still belongs to this command.
                if (any_done) begin
                    if (pl_cnt_d != cmd_count_q) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_COUNT;
                    end
                    state_d = frame_end_d ? ST_DONE : ST_DRAIN;
                end else if (to_expired) begin
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = ST_ERROR;
                end
            end
            state_q[S_DRAIN]: if (xfer && rx_tlast) state_d = ST_DONE;
            state_q[S_DONE]:  state_d = ST_IDLE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            csn_q       <= '0;
            cmd_code_q  <= '0;
            cmd_count_q <= '0;
            pl_cnt_q    <= '0;
            frame_end_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            csn_q       <= csn_d;
            cmd_code_q  <= cmd_code_d;
            cmd_count_q <= cmd_count_d;
            pl_cnt_q    <= pl_cnt_d;
            frame_end_q <= frame_end_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign csn        = csn_q;
    assign cmd_code   = cmd_code_q;
    assign cmd_count  = cmd_count_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign run_cmd_sm = state_q[S_START] | state_q[S_PAUSE] | state_q[S_TEST_RUNNING]
                      | state_q[S_WAIT_DONE];
    assign cmd_done   = state_q[S_DONE];
    assign busy       = ~state_q[S_IDLE];

endmodule

// File: tb/tb_cmd_dispatch_sm.sv
// Randomised bench for cmd_dispatch_sm: a transaction-level model predicts every
// output each cycle; directed frames pin the model with hand-computed values.
module tb_cmd_dispatch_sm;

    localparam int DW = 32;
    localparam int NH = 8;
    localparam int TO = 100;

    logic clk = 1'b0, reset_n = 1'b0;
    logic rx_tvalid = 1'b0, rx_tlast = 1'b0, hdl_rx_tready = 1'b0;
    logic [DW-1:0] rx_tdata = '0;
    logic [NH-1:0] running = '0, done = '0;
    logic rx_tready, run_cmd_sm, cmd_done, err_valid, busy;
    logic [DW-1:0] csn, cmd_code, cmd_count;
    logic [2:0] err_code;

    cmd_dispatch_sm #(.DATA_W(DW), .N_HANDLERS(NH), .TIMEOUT_CYC(TO), .TO_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .rx_tvalid(rx_tvalid), .rx_tdata(rx_tdata),
        .rx_tlast(rx_tlast), .rx_tready(rx_tready), .hdl_rx_tready(hdl_rx_tready),
        .csn(csn), .cmd_code(cmd_code), .cmd_count(cmd_count), .run_cmd_sm(run_cmd_sm),
        .cmd_sm_running(running), .cmd_sm_done(done), .cmd_done(cmd_done),
        .err_valid(err_valid), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (command-level phases) ----------------
    localparam int P_PARSE = 0, P_DISP = 1, P_WAIT = 2, P_REPORT = 3, P_DRAIN = 4, P_FINISH = 5;
    int m_phase, m_hdr, m_dly, m_waited;
    bit m_pend_illegal, m_fend, m_errv;
    logic [2:0] m_errc;
    logic [DW-1:0] m_csn, m_cc, m_cnt, m_pl;

    function automatic bit m_tready();
        if (m_phase == P_PARSE || m_phase == P_DRAIN) return 1'b1;
        if (m_phase == P_WAIT) return hdl_rx_tready && !m_fend;
        return 1'b0;
    endfunction

    task automatic m_reset();
        m_phase = P_PARSE; m_hdr = 0; m_dly = 0; m_waited = 0; m_pend_illegal = 0;
        m_fend = 0; m_errv = 0; m_errc = 0; m_csn = 0; m_cc = 0; m_cnt = 0; m_pl = 0;
    endtask

    task automatic m_err(input logic [2:0] c);
        m_errv = 1'b1; m_errc = c;
    endtask

    task automatic m_step();
        bit x;
        int n;
        x = rx_tvalid && m_tready();
        m_errv = 1'b0;
        case (m_phase)
            P_PARSE: if (x) begin
                if (m_hdr == 0) begin
                    if (rx_tlast) m_err(3); else begin m_csn = rx_tdata; m_hdr = 1; end
                end else if (m_hdr == 1) begin
                    if (rx_tlast) begin m_err(3); m_hdr = 0; m_phase = P_FINISH; end
                    else begin m_cc = rx_tdata; m_hdr = 2; end
                end else begin
                    m_cnt = rx_tdata; m_fend = rx_tlast; m_hdr = 0;
                    if (rx_tlast && rx_tdata != 0) begin m_err(3); m_phase = P_FINISH; end
                    else begin m_phase = P_DISP; m_dly = 2; end
                end
            end
            P_DISP: if (m_dly > 0) m_dly--;
            else begin
                n = $countones(running);
                if (n == 1) begin m_phase = P_WAIT; m_waited = 0; m_pl = 0; end
                else if (n == 0) begin m_phase = P_REPORT; m_pend_illegal = 1; end
                else begin m_err(4); m_phase = P_REPORT; m_pend_illegal = 0; end
            end
            P_REPORT: begin
                if (m_pend_illegal) m_err(1);
                m_phase = m_fend ? P_FINISH : P_DRAIN;
            end
            P_WAIT: begin
                if (x) begin
                    if (m_pl != '1) m_pl = m_pl + 1;
                    if (rx_tlast) m_fend = 1;
                end
                m_waited++;
                if (|done) begin
                    if (m_pl != m_cnt) m_err(5);
                    m_phase = m_fend ? P_FINISH : P_DRAIN;
                end else if (TO != 0 && m_waited == TO) begin
                    m_err(2); m_phase = P_REPORT; m_pend_illegal = 0;
                end
            end
            P_DRAIN:  if (x && rx_tlast) m_phase = P_FINISH;
            default:  m_phase = P_PARSE;
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset(); else m_step();
        end
    end

    // Compare process: every cycle out of reset, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            chk("rx_tready",  rx_tready, m_tready());
            chk("busy",       busy, !(m_phase == P_PARSE && m_hdr == 0));
            chk("run_cmd_sm", run_cmd_sm, (m_phase == P_DISP || m_phase == P_WAIT));
            chk("cmd_done",   cmd_done, m_phase == P_FINISH);
            chk("err_valid",  err_valid, m_errv);
            chk("err_code",   err_code, m_errc);
            chk("csn",        csn, m_csn);
            chk("cmd_code",   cmd_code, m_cc);
            chk("cmd_count",  cmd_count, m_cnt);
        end
    end

    // ---------------- event monitor for the literal checks ----------------
    int ev_done, ev_err, ev_rel, mon_rel;
    logic [2:0] ev_code;
    bit mon_prev;
    initial forever begin
        @(negedge clk);
        if (!reset_n) mon_prev = 0;
        else begin
            if (run_cmd_sm && !mon_prev) mon_rel = 0; else mon_rel++;
            mon_prev = run_cmd_sm;
            if (cmd_done) ev_done++;
            if (err_valid) begin ev_err++; ev_code = err_code; ev_rel = mon_rel; end
        end
    end

    task automatic clr_ev();
        ev_done = 0; ev_err = 0; ev_rel = -1; ev_code = 0;
    endtask

    // ---------------- handler emulation ----------------
    logic [NH-1:0] h_mask;
    int h_consume, h_done_at, h_rdy_pct, h_rel, h_consumed;
    bit h_prev;
    initial begin
        h_mask = '0; h_consume = 0; h_done_at = -1; h_rdy_pct = 100; h_prev = 0;
        forever begin
            bit r;
            @(negedge clk);
            r = run_cmd_sm;
            if (r && !h_prev) begin h_rel = 0; h_consumed = 0; end else h_rel++;
            if (r && rx_tvalid && rx_tready) h_consumed++;
            h_prev = r;
            @(posedge clk); #1;
            running       = r ? h_mask : (($urandom_range(3) == 0) ? NH'($urandom) : '0);
            if (r) done   = (h_rel + 1 == h_done_at) ? ((h_mask != 0) ? h_mask : NH'(1)) : '0;
            else   done   = ($urandom_range(4) == 0) ? NH'($urandom) : '0;
            hdl_rx_tready = r ? (h_consumed < h_consume && $urandom_range(99) < h_rdy_pct)
                              : 1'($urandom_range(1));
        end
    end

    task automatic cfg(input logic [NH-1:0] m, input int cons, input int dat, input int rdy);
        h_mask = m; h_consume = cons; h_done_at = dat; h_rdy_pct = rdy;
    endtask

    // ---------------- rx driver (tasks start/end at posedge+1) ----------------
    int gap_max = 0;
    logic [DW-1:0] fq_d[$];
    bit fq_l[$];

    task automatic push(input logic [DW-1:0] d, input bit l);
        fq_d.push_back(d); fq_l.push_back(l);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input bit last);
        int g, n;
        bit acc;
        g = (gap_max > 0) ? $urandom_range(gap_max) : 0;
        repeat (g) begin @(posedge clk); #1; end
        rx_tvalid = 1; rx_tdata = d; rx_tlast = last;
        n = 0; acc = 0;
        while (!acc && n < 400) begin
            @(negedge clk); acc = rx_tready;
            @(posedge clk); #1; n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: word %0h not accepted, required within 400 cycles", d);
        end
        rx_tvalid = 0; rx_tdata = DW'($urandom); rx_tlast = 0;
    endtask

    task automatic send_frame();
        while (fq_d.size() > 0) send_word(fq_d.pop_front(), fq_l.pop_front());
    endtask

    task automatic wait_idle();
        int n;
        bit b;
        n = 0; b = 1;
        while (b && n < 600) begin @(negedge clk); b = busy; n++; end
        if (b) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy still 1, required 0 within 600 cycles");
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic rand_frame();
        int kind, cdc, np;
        logic [NH-1:0] m;
        int sel;
        gap_max = $urandom_range(3);
        sel = $urandom_range(99);
        if (sel < 70)      m = NH'(1) << $urandom_range(NH-1);
        else if (sel < 85) m = '0;
        else               m = (NH'(1) << $urandom_range(3)) | (NH'(1) << (4 + $urandom_range(3)));
        kind = $urandom_range(9);
        cdc  = $urandom_range(4);
        np   = cdc;
        if ($urandom_range(3) == 0) np = (cdc > 0 && $urandom_range(1)) ? cdc - 1 : cdc + 1;
        cfg(m, (cdc == 0) ? $urandom_range(1) : cdc - 1 + $urandom_range(2),
            ($urandom_range(4) == 0) ? -1 : 3 + $urandom_range(1, 20), 40 + $urandom_range(60));
        if (kind == 0) push(DW'($urandom), 1);
        else if (kind == 1) begin push(DW'($urandom), 0); push(DW'($urandom), 1); end
        else if (kind == 2) begin
            push(DW'($urandom), 0); push(DW'($urandom), 0); push(DW'($urandom_range(2)), 1);
        end else begin
            push(DW'($urandom), 0); push(DW'($urandom), 0); push(DW'(cdc), np == 0);
            for (int i = 0; i < np; i++) push(DW'($urandom), i == np - 1);
        end
        send_frame();
        wait_idle();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        clr_ev();
        repeat (3) @(negedge clk);
        chk("rst_csn", csn, 0);         chk("rst_cmd_code", cmd_code, 0);
        chk("rst_cmd_count", cmd_count, 0); chk("rst_err_code", DW'(err_code), 0);
        chk("rst_err_valid", DW'(err_valid), 0); chk("rst_run", DW'(run_cmd_sm), 0);
        chk("rst_cmd_done", DW'(cmd_done), 0);   chk("rst_busy", DW'(busy), 0);
        #1 reset_n = 1;
        @(posedge clk); #1;

        // Nominal command: handler 3 consumes both words, done 10 cycles into WAIT_DONE.
        clr_ev(); cfg(8'h08, 2, 13, 100);
        push(32'h11, 0); push(32'h5, 0); push(32'd2, 0); push(32'hA1, 0); push(32'hA2, 1);
        send_frame(); wait_idle();
        chk("t1_csn", csn, 32'h11); chk("t1_cmd_code", cmd_code, 32'h5);
        chk("t1_cmd_count", cmd_count, 32'd2);
        chk("t1_done_cnt", DW'(ev_done), 1); chk("t1_err_cnt", DW'(ev_err), 0);

        // Unclaimed command code, payload drained.
        clr_ev(); cfg('0, 0, -1, 100);
        push(32'h12, 0); push(32'h99, 0); push(32'd1, 0); push(32'hB1, 1);
        send_frame(); wait_idle();
        chk("t2_err_code", DW'(ev_code), 1); chk("t2_err_cnt", DW'(ev_err), 1);
        chk("t2_done_cnt", DW'(ev_done), 1);

        // Handler never finishes: timeout lands 100 cycles after WAIT_DONE entry.
        clr_ev(); cfg(8'h02, 0, -1, 100);
        push(32'h13, 0); push(32'h7, 0); push(32'd2, 0); push(32'hC1, 0); push(32'hC2, 1);
        send_frame(); wait_idle();
        chk("t3_err_code", DW'(ev_code), 2); chk("t3_err_rel", DW'(ev_rel), 3 + TO);
        chk("t3_done_cnt", DW'(ev_done), 1);

        // Short frame, recovery frame, lone tlast word.
        clr_ev(); cfg(8'h01, 0, 5, 100);
        push(32'h14, 0); push(32'h3, 1);
        send_frame(); wait_idle();
        chk("t4_err_code", DW'(ev_code), 3);
        clr_ev(); cfg(8'h01, 1, 8, 100);
        push(32'h15, 0); push(32'h4, 0); push(32'd1, 0); push(32'hD1, 1);
        send_frame(); wait_idle();
        chk("t4_ok_err_cnt", DW'(ev_err), 0); chk("t4_ok_csn", csn, 32'h15);
        clr_ev(); push(32'hEE, 1); send_frame(); wait_idle();
        chk("t4_lone_err", DW'(ev_code), 3); chk("t4_lone_done", DW'(ev_done), 0);

        // Two claimants, then a count mismatch with the third word drained.
        clr_ev(); cfg(8'h12, 0, -1, 100);
        push(32'h16, 0); push(32'h8, 0); push(32'd1, 0); push(32'hE1, 1);
        send_frame(); wait_idle();
        chk("t5_multi_err", DW'(ev_code), 4);
        clr_ev(); cfg(8'h04, 2, 11, 100);
        push(32'h17, 0); push(32'h9, 0); push(32'd3, 0);
        push(32'hF1, 0); push(32'hF2, 0); push(32'hF3, 1);
        send_frame(); wait_idle();
        chk("t5_count_err", DW'(ev_code), 5); chk("t5_count_done", DW'(ev_done), 1);

        // Done arrives in the very cycle the timeout would fire: done wins.
        clr_ev(); cfg(8'h40, 1, 3 + TO - 1, 100);
        push(32'h18, 0); push(32'hA, 0); push(32'd1, 0); push(32'h51, 1);
        send_frame(); wait_idle();
        chk("tie_err_cnt", DW'(ev_err), 0); chk("tie_done_cnt", DW'(ev_done), 1);

        // Reset mid WAIT_DONE, rest of frame resyncs through the tlast discard.
        clr_ev(); cfg(8'h10, 0, -1, 100);
        push(32'h19, 0); push(32'hB, 0); push(32'd1, 0);
        send_frame();
        repeat (6) begin @(posedge clk); #1; end
        @(negedge clk); #2 reset_n = 0; #1;
        chk("mr_csn", csn, 0); chk("mr_cmd_code", cmd_code, 0); chk("mr_cmd_count", cmd_count, 0);
        chk("mr_run", DW'(run_cmd_sm), 0); chk("mr_busy", DW'(busy), 0);
        chk("mr_err_valid", DW'(err_valid), 0); chk("mr_err_code", DW'(err_code), 0);
        chk("mr_cmd_done", DW'(cmd_done), 0);
        @(negedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        clr_ev(); send_word(32'h61, 1); wait_idle();
        chk("mr_resync_err", DW'(ev_code), 3);

        for (int i = 0; i < 40; i++) rand_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
